lsu_split_access: RTL



---
 rtl/lsu_split_access.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lsu_split_access.sv
// lsu_split_access: registered MEM-stage data access unit in front of a
// single-port word dcache. Misaligned accesses that cross a word boundary are
// issued as two word beats; load data is merged, lane-aligned and extended.
module lsu_split_access #(
  parameter int DADDR_WIDTH = 12,
  parameter bit SPLIT_EN    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [2:0]             req_mode,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic [DADDR_WIDTH-1:0] dcache_addr,
  output logic                   dcache_ceb,
  output logic [3:0]             dcache_bweb,
  output logic [31:0]            dcache_wdata,
  input  logic [31:0]            dcache_rdata
);

  localparam int AW = DADDR_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t r_state, w_next;

  logic                   r_write;
  logic [2:0]             r_mode;
  logic [AW-1:0]          r_addr;
  logic [31:0]            r_wdata;
  logic                   r_err;
  logic [31:0]            r_buf;

  logic                   w_req_misal;
  logic                   w_req_err;
  logic [1:0]             w_off;
  logic [2:0]             w_nbytes;
  logic [3:0]             w_bmask;
  logic [7:0]             w_mask8;
  logic [31:0]            w_wmask;
  logic [63:0]            w_win;
  logic                   w_split;
  logic [DADDR_WIDTH-1:0] w_word0;
  logic [DADDR_WIDTH-1:0] w_word1;
  logic [63:0]            w_ld;
  logic [31:0]            w_field;
  logic                   w_sext;
  logic [31:0]            w_ext;
  logic                   w_unused_addr;

  // Address bits above the dcache range do not select anything.
  assign w_unused_addr = |req_addr[31:AW];

  // Classify the incoming request: reserved size, or misaligned when splitting is disabled.
  always_comb begin
    w_req_misal = 1'b0;
    case (req_mode[1:0])
      2'b01:   w_req_misal = req_addr[0];
      2'b10:   w_req_misal = |req_addr[1:0];
      default: w_req_misal = 1'b0;
    endcase
    w_req_err = (req_mode[1:0] == 2'b11) || (!SPLIT_EN && w_req_misal);
  end

  // Size decode of the latched request into byte count and lane mask.
  always_comb begin
    w_nbytes = 3'd0;
    w_bmask  = 4'b0000;
    case (r_mode[1:0])
      2'b00:   begin w_nbytes = 3'd1; w_bmask = 4'b0001; end
      2'b01:   begin w_nbytes = 3'd2; w_bmask = 4'b0011; end
      2'b10:   begin w_nbytes = 3'd4; w_bmask = 4'b1111; end
      default: begin w_nbytes = 3'd0; w_bmask = 4'b0000; end
    endcase
  end

  assign w_off   = r_addr[1:0];
  assign w_split = (({1'b0, w_off} + w_nbytes) > 3'd4);
  assign w_mask8 = {4'b0000, w_bmask} << w_off;
  assign w_wmask = {{8{w_bmask[3]}}, {8{w_bmask[2]}}, {8{w_bmask[1]}}, {8{w_bmask[0]}}};
  // Store data placed in a two-word window; beat0 takes the low word, beat1 the high.
  assign w_win   = {32'h0, r_wdata & w_wmask} << {w_off, 3'b000};
  assign w_word0 = r_addr[AW-1:2];
  assign w_word1 = w_word0 + DADDR_WIDTH'(1);

  // Load merge: last beat arrives in RESP, earlier beat comes from the buffer.
  assign w_ld    = w_split ? {dcache_rdata, r_buf} : {32'h0, dcache_rdata};
  assign w_field = 32'(w_ld >> {w_off, 3'b000});
  assign w_sext  = ~r_mode[2];

  // Truncate the aligned field to the access size and extend.
  always_comb begin
    w_ext = w_field;
    case (r_mode[1:0])
      2'b00:   w_ext = {{24{w_sext & w_field[7]}}, w_field[7:0]};
      2'b01:   w_ext = {{16{w_sext & w_field[15]}}, w_field[15:0]};
      default: w_ext = w_field;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Request latch on acceptance and beat0 read-data capture during BEAT1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write <= 1'b0;
      r_mode  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_buf   <= '0;
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_write <= req_write;
        r_mode  <= req_mode;
        r_addr  <= req_addr[AW-1:0];
        r_wdata <= req_wdata;
        r_err   <= w_req_err;
      end
      if (r_state == BEAT1) r_buf <= dcache_rdata;
    end
  end

  // Next-state and state-decoded outputs; idle values double as reset values.
  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = '0;
    dcache_ceb   = 1'b1;
    dcache_bweb  = '1;
    dcache_addr  = '0;
    dcache_wdata = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_req_err ? RESP : BEAT0;
      end
      BEAT0: begin
        dcache_ceb  = 1'b0;
        dcache_addr = w_word0;
        if (r_write) begin
          dcache_bweb  = ~w_mask8[3:0];
          dcache_wdata = w_win[31:0];
        end
        w_next = w_split ? BEAT1 : RESP;
      end
      BEAT1: begin
        dcache_ceb  = 1'b0;
        dcache_addr = w_word1;
        if (r_write) begin
          dcache_bweb  = ~w_mask8[7:4];
          dcache_wdata = w_win[63:32];
        end
        w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        if (!r_err && !r_write) resp_rdata = w_ext;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
